// File: rtl/pipe_ctl_regs.sv
// rtl/pipe_ctl_regs.sv - control-side ID/EX, EX/MEM, MEM/WB pipeline registers with bubble and hold
// Optional performance counters are enabled by defining PIPE_PERF_EN.
module pipe_ctl_regs #(
  parameter int         CNT_W  = 32,
  parameter logic [4:0] JAL_RN = 5'd31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             nostall,
  input  logic             wreg,
  input  logic             m2reg,
  input  logic             wmem,
  input  logic [3:0]       aluc,
  input  logic             aluimm,
  input  logic             shift,
  input  logic             jal,
  input  logic             regrt,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ealuimm,
  output logic             eshift,
  output logic             ejal,
  output logic [3:0]       ealuc,
  output logic [4:0]       ern,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [4:0]       mrn,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [4:0]       wrn,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] ret_cnt,
`endif
  output logic             retire
);

  logic       ewreg_q, em2reg_q, ewmem_q, ealuimm_q, eshift_q, ejal_q, evalid_q;
  logic [3:0] ealuc_q;
  logic [4:0] ern_q;
  logic       mwreg_q, mm2reg_q, mwmem_q, mvalid_q;
  logic [4:0] mrn_q;
  logic       wwreg_q, wm2reg_q, wvalid_q;
  logic [4:0] wrn_q;

  logic       ewreg_d, em2reg_d, ewmem_d, ealuimm_d, eshift_d, ejal_d;
  logic [3:0] ealuc_d;
  logic [4:0] ern_d;

  // A stalled slot enters EX as an all-zero bubble so ern=0 never aliases a hazard source.
  always_comb begin
    ewreg_d   = 1'b0;
    em2reg_d  = 1'b0;
    ewmem_d   = 1'b0;
    ealuimm_d = 1'b0;
    eshift_d  = 1'b0;
    ejal_d    = 1'b0;
    ealuc_d   = 4'd0;
    ern_d     = 5'd0;
    if (nostall) begin
      ewreg_d   = wreg;
      em2reg_d  = m2reg;
      ewmem_d   = wmem;
      ealuimm_d = aluimm;
      eshift_d  = shift;
      ejal_d    = jal;
      ealuc_d   = aluc;
      ern_d     = jal ? JAL_RN : (regrt ? rt : rd);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ewreg_q   <= 1'b0;
      em2reg_q  <= 1'b0;
      ewmem_q   <= 1'b0;
      ealuimm_q <= 1'b0;
      eshift_q  <= 1'b0;
      ejal_q    <= 1'b0;
      ealuc_q   <= 4'd0;
      ern_q     <= 5'd0;
      evalid_q  <= 1'b0;
      mwreg_q   <= 1'b0;
      mm2reg_q  <= 1'b0;
      mwmem_q   <= 1'b0;
      mrn_q     <= 5'd0;
      mvalid_q  <= 1'b0;
      wwreg_q   <= 1'b0;
      wm2reg_q  <= 1'b0;
      wrn_q     <= 5'd0;
      wvalid_q  <= 1'b0;
    end else if (ce) begin
      ewreg_q   <= ewreg_d;
      em2reg_q  <= em2reg_d;
      ewmem_q   <= ewmem_d;
      ealuimm_q <= ealuimm_d;
      eshift_q  <= eshift_d;
      ejal_q    <= ejal_d;
      ealuc_q   <= ealuc_d;
      ern_q     <= ern_d;
      evalid_q  <= nostall;
      mwreg_q   <= ewreg_q;
      mm2reg_q  <= em2reg_q;
      mwmem_q   <= ewmem_q;
      mrn_q     <= ern_q;
      mvalid_q  <= evalid_q;
      wwreg_q   <= mwreg_q;
      wm2reg_q  <= mm2reg_q;
      wrn_q     <= mrn_q;
      wvalid_q  <= mvalid_q;
    end
  end

  assign ewreg   = ewreg_q;
  assign em2reg  = em2reg_q;
  assign ewmem   = ewmem_q;
  assign ealuimm = ealuimm_q;
  assign eshift  = eshift_q;
  assign ejal    = ejal_q;
  assign ealuc   = ealuc_q;
  assign ern     = ern_q;
  assign mwreg   = mwreg_q;
  assign mm2reg  = mm2reg_q;
  assign mwmem   = mwmem_q;
  assign mrn     = mrn_q;
  assign wwreg   = wwreg_q;
  assign wm2reg  = wm2reg_q;
  assign wrn     = wrn_q;
  assign retire  = wvalid_q & ce;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q, ret_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (ce && !nostall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (retire)         ret_cnt_q   <= ret_cnt_q + 1'b1;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign ret_cnt   = ret_cnt_q;
`endif

endmodule
